// File: rtl/atari_board_ctrl.sv
// atari_board_ctrl: board-level glue between the iCEBreaker buttons/PLL and the
// Atari 2600 core. It sequences the core reset (power-on hold and long-press reset),
// debounces the buttons onto the core input bus, and drives a heartbeat LED.
// Optional build macro ATARI_AUTOFIRE_EN turns a held FIRE into an autofire square wave.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// POR      0| core held in reset until PLL has been locked POR_CYCLES clocks
// RUN      1| core running, buttons passed through
// ARMED    2| reset button held, timing the long press
// RESET    3| forced core reset pulse of RST_PULSE_CYCLES clocks
// WAIT_REL 4| core running, console RESET masked until the button is released
module atari_board_ctrl #(
  parameter int POR_CYCLES       = 1024,
  parameter int HOLD_CYCLES      = 25200000,
  parameter int RST_PULSE_CYCLES = 64,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int AUTOFIRE_CYCLES  = 420000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       btn_n,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  output logic       core_rst_n,
  output logic [7:0] ui_in,
  output logic       led_heartbeat,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_POR      = 3'd0,
    ST_RUN      = 3'd1,
    ST_ARMED    = 3'd2,
    ST_RESET    = 3'd3,
    ST_WAIT_REL = 3'd4
  } state_t;

  localparam int MAX_AB  = (POR_CYCLES > HOLD_CYCLES) ? POR_CYCLES : HOLD_CYCLES;
  localparam int MAX_ABC = (MAX_AB > RST_PULSE_CYCLES) ? MAX_AB : RST_PULSE_CYCLES;
  localparam int MAX_CYC = (MAX_ABC > AUTOFIRE_CYCLES) ? MAX_ABC : AUTOFIRE_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HBW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CW-1:0]  POR_LAST   = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0]  HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  PULSE_LAST = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HBW-1:0] HB_LAST    = HBW'(HOLD_CYCLES - 1);

  // All buttons are handled as active-high "pressed"; bit 0 is the inverted reset
  // button, so a cleared debounced bit 0 means btn_n is released.
  logic [3:0]          raw, sync1, sync2, db;
  logic [3:0][DBW-1:0] db_cnt;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [HBW-1:0]      hb_cnt;
  logic [7:0]          ui_d;
  logic                run_like_d;
  logic                fire_bit;

  assign raw = {btn3, btn2, btn1, ~btn_n};

  // Two-flop synchronizer for every raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debouncer: accept a change only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db     <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // FSM state and shared timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_POR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; losing PLL lock overrides everything outside POR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_POR: begin
        if (!pll_locked) begin
          cnt_d = '0;
        end else if (cnt_q == POR_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (db[0]) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        if (!db[0]) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESET: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_WAIT_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (!db[0]) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_POR;
        cnt_d   = '0;
      end
    endcase
    if (state_q != ST_POR && !pll_locked) begin
      state_d = ST_POR;
      cnt_d   = '0;
    end
  end

`ifdef ATARI_AUTOFIRE_EN
  localparam logic [CW-1:0] AF_LAST = CW'(AUTOFIRE_CYCLES - 1);
  logic [CW-1:0] af_cnt;
  logic          af_phase;

  // Autofire square wave; restarts high on every press and whenever the core is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (!db[1] || state_d == ST_POR || state_d == ST_RESET) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (af_cnt == AF_LAST) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end

  assign fire_bit = db[1] & af_phase;
`else
  assign fire_bit = db[1];
`endif

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    ui_d       = '0;
    run_like_d = (state_d == ST_RUN) || (state_d == ST_ARMED) || (state_d == ST_WAIT_REL);
    if (state_d != ST_POR && state_d != ST_RESET) begin
      ui_d[0] = db[0] && (state_d == ST_RUN || state_d == ST_ARMED);
      ui_d[1] = fire_bit;
      ui_d[5] = db[2];
      ui_d[6] = db[3];
    end
  end

  // Registered core reset and input bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rst_n <= 1'b0;
      ui_in      <= '0;
    end else begin
      core_rst_n <= run_like_d;
      ui_in      <= ui_d;
    end
  end

  // Free-running heartbeat, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt        <= '0;
      led_heartbeat <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt        <= '0;
      led_heartbeat <= ~led_heartbeat;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  assign state = state_q;

endmodule
